x86_regfile_mp: RTL
===================

Name: x86_regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the 8086 datapath.
- Successor to the fixed 4×8-bit, fixed-port-mapping file.
- Adds generic width/depth, arbitrary addressed read and write ports, and 8086 byte-lane (AL/AH-style) writes with deterministic write-port priority.
- Adds optional write-to-read bypass and a per-register busy scoreboard, so the decode stage can track pending writebacks.

Parameters:
- DATA_W, 16, register width in bits; must be a multiple of 8.
- NUM_REGS, 8, number of registers (AX,CX,DX,BX,SP,BP,SI,DI); need not be a power of 2.
- NUM_RD, 3, number of read ports.
- NUM_WR, 2, number of write ports; higher port index has higher priority.
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return stored value only.
- Derived, not overridable: ADDR_W = max(1, clog2(NUM_REGS)); LANES = DATA_W/8.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  busy bit of the addressed register, combinational
- wr_en  in  NUM_WR  write-port valid
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- wr_be  in  NUM_WR*LANES  byte enables; lane 0 = bits [7:0]
- rsv_en  in  1  reserve request: mark rsv_addr busy (writeback pending)
- rsv_addr  in  ADDR_W  register being reserved
- busy  out  NUM_REGS  registered scoreboard vector
- rsv_conflict  out  1  registered one-cycle flag: reserve hit an already-busy register

Behaviour:
- Reset: all registers = 0, busy = 0, rsv_conflict = 0. Asynchronous; takes effect mid-operation. Writes and reserves in the reset cycle are discarded.
- Write (posedge): for each register r and lane l, lane updates if any port p has wr_en[p] & wr_addr[p]==r & wr_be[p][l].
  - Data is taken from the highest-index qualifying port.
  - Lanes without a qualifying port hold their value.
  - wr_en=1 with wr_be=0: no data change, still counts as writeback for the scoreboard.
- Read: rd_data[i] = registers[rd_addr[i]], zero latency.
  - BYPASS=1: each lane is replaced by the winning same-cycle write lane, so the value matches the register content after the edge.
  - BYPASS=0: pre-edge value.
- Out-of-range address (≥ NUM_REGS):
  - Write lanes are ignored.
  - Read returns 0; rd_busy = 0.
  - Reserve is ignored, with no conflict.
- Scoreboard, per register r, next state:
  - Set if rsv_en & rsv_addr==r.
  - Else cleared if any wr_en[p] & wr_addr[p]==r.
  - Else held.
  - Simultaneous reserve and writeback on the same r: reserve wins, busy stays 1 (new owner) and no conflict.
- rsv_conflict:
  - Next cycle = rsv_en & busy[rsv_addr] & no same-cycle writeback to rsv_addr.
  - Otherwise 0. Pulses for one cycle per offending request.
- rd_busy[i] = busy[rd_addr[i]] (pre-edge, never bypassed).
- Multiple read ports may address the same register; no limit.

Decomposition:
- Package x86_regfile_pkg:
  - Register index constants REG_AX=0, REG_CX=1, REG_DX=2, REG_BX=3, REG_SP=4, REG_BP=5, REG_SI=6, REG_DI=7.
  - Function lanes_of(width).
  - Function addr_w_of(n).
- Sub-module x86_regfile_lane_merge:
  - Inputs: one register's current value plus all write ports' data, enables, byte enables and address-match bits.
  - Output: merged next value using priority lane selection.
  - Instantiated NUM_REGS times; its output is also the bypass source.

Test Plan:
- Reset then read all regs on 3 ports -> every rd_data = 0x0000, busy = 0x00, rsv_conflict = 0.
- Port0 writes BX=0x1234 be=11; next cycle port1 writes BX be=10 data 0xAB00 -> BX = 0xAB34. BYPASS=1: same-cycle read of BX shows 0xAB34; BYPASS=0 build shows 0x1234.
- Both ports write CX be=11 in one cycle, port0 0x1111 and port1 0x2222 -> CX = 0x2222. Then port0 be=01 0x00EE, port1 be=10 0x7700 -> CX = 0x77EE.
- Reserve DX, read DX -> rd_busy = 1. Writeback DX -> busy[2] = 0 next cycle. Reserve DX twice without writeback -> rsv_conflict = 1 for exactly one cycle; busy stays 1.
- Same cycle: reserve SI and write SI -> busy[6] stays 1, rsv_conflict = 0, SI holds the written data.
- NUM_REGS=6 build: write/read/reserve addr 7 -> no state change, rd_data = 0, rd_busy = 0. Assert rst asynchronously between edges while busy = 0x3F -> busy and data clear immediately.

Source files
------------

// File: rtl/x86_regfile_pkg.sv
// Shared constants and sizing helpers for the 8086 general-purpose register file.
package x86_regfile_pkg;

  localparam int REG_AX = 0;
  localparam int REG_CX = 1;
  localparam int REG_DX = 2;
  localparam int REG_BX = 3;
  localparam int REG_SP = 4;
  localparam int REG_BP = 5;
  localparam int REG_SI = 6;
  localparam int REG_DI = 7;

  function automatic int lanes_of(input int width);
    return width / 8;
  endfunction

  // Address width never drops below one bit, even for a single-register file.
  function automatic int addr_w_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/x86_regfile_lane_merge.sv
// Next-value builder for one register: per byte lane, the highest-index
// write port that targets this register with that lane enabled wins.
module x86_regfile_lane_merge
  import x86_regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_WR = 2,
  localparam int LANES = lanes_of(DATA_W)
) (
  input  logic [DATA_W-1:0]        cur_val,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR-1:0]        wr_match,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR*LANES-1:0]  wr_be,
  output logic [DATA_W-1:0]        nxt_val
);

  // Ascending port order lets later (higher-priority) ports overwrite earlier ones.
  always_comb begin
    nxt_val = cur_val;
    for (int p = 0; p < NUM_WR; p++) begin
      for (int l = 0; l < LANES; l++) begin
        if (wr_en[p] && wr_match[p] && wr_be[p*LANES + l]) begin
          nxt_val[l*8 +: 8] = wr_data[p*DATA_W + l*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/x86_regfile_mp.sv
// Multi-port 8086 register file with byte-lane writes, optional write-to-read
// bypass and a per-register busy scoreboard for pending writebacks.
module x86_regfile_mp
  import x86_regfile_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 3,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = addr_w_of(NUM_REGS),
  localparam int LANES   = lanes_of(DATA_W)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic [NUM_WR*LANES-1:0]    wr_be,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic [NUM_REGS-1:0]        busy,
  output logic                       rsv_conflict
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_WR-1:0]   wr_match [NUM_REGS];
  logic [NUM_REGS-1:0] wb_hit;
  logic [NUM_REGS-1:0] rsv_hit;
  logic [NUM_REGS-1:0] busy_d, busy_q;
  logic                rsv_conflict_d, rsv_conflict_q;

  // Out-of-range addresses never match any register, so they fall away naturally.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int p = 0; p < NUM_WR; p++) begin
        wr_match[r][p] = (wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r));
      end
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    x86_regfile_lane_merge #(
      .DATA_W (DATA_W),
      .NUM_WR (NUM_WR)
    ) u_merge (
      .cur_val  (regs_q[r]),
      .wr_en    (wr_en),
      .wr_match (wr_match[r]),
      .wr_data  (wr_data),
      .wr_be    (wr_be),
      .nxt_val  (regs_d[r])
    );
  end

  // A reservation outranks a same-cycle writeback: the register gets a new owner.
  always_comb begin
    rsv_conflict_d = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      wb_hit[r]  = |(wr_en & wr_match[r]);
      rsv_hit[r] = rsv_en && (rsv_addr == ADDR_W'(r));
      if (rsv_hit[r]) begin
        busy_d[r] = 1'b1;
      end else if (wb_hit[r]) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
      rsv_conflict_d = rsv_conflict_d | (rsv_hit[r] & busy_q[r] & ~wb_hit[r]);
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (rd_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
          rd_data[i*DATA_W +: DATA_W] = (BYPASS != 0) ? regs_d[r] : regs_q[r];
          rd_busy[i] = busy_q[r];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q         <= '0;
      rsv_conflict_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q         <= busy_d;
      rsv_conflict_q <= rsv_conflict_d;
    end
  end

  assign busy         = busy_q;
  assign rsv_conflict = rsv_conflict_q;

endmodule
